// File: rtl/shift_add_multiplier_param.sv
// Sequential shift-and-add multiplier with a runtime signed/unsigned mode.
// An operation takes WIDTH iterations of the CALC state after the start edge.
// Signed operands are converted to magnitudes on entry, and the sign is
// reapplied to the final 2*WIDTH-bit product.
module shift_add_multiplier_param #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 st_i,
  input  logic                 signed_i,
  input  logic [WIDTH-1:0]     mcand_i,
  input  logic [WIDTH-1:0]     mplier_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   product_o
);

  // The counter only has to reach WIDTH-1.
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {S_IDLE, S_CALC} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_mcand;
  logic                 r_neg;
  logic                 r_done;
  logic [2*WIDTH-1:0]   r_product;

  logic                 w_start;
  logic                 w_last;
  logic signed [WIDTH-1:0] w_mcand_s;
  logic signed [WIDTH-1:0] w_mplier_s;
  logic [WIDTH-1:0]     w_mcand_mag;
  logic [WIDTH-1:0]     w_mplier_mag;
  logic                 w_neg_in;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_acc_nxt;

  // Two's-complement magnitude of a WIDTH-bit operand. The most negative
  // value maps to 2^(WIDTH-1), which still fits as an unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
    logic [WIDTH-1:0] u;
    u = v;
    return (v < 0) ? (~u + 1'b1) : u;
  endfunction

  // Two's-complement negation of the full-width product. Zero maps to zero.
  function automatic logic [2*WIDTH-1:0] negate(input logic [2*WIDTH-1:0] v);
    return ~v + 1'b1;
  endfunction

  assign w_start    = (r_state == S_IDLE) && st_i;
  assign w_last     = (r_state == S_CALC) && (r_cnt == LAST_CNT);
  assign w_mcand_s  = mcand_i;
  assign w_mplier_s = mplier_i;

  assign w_mcand_mag  = signed_i ? magnitude(w_mcand_s)  : mcand_i;
  assign w_mplier_mag = signed_i ? magnitude(w_mplier_s) : mplier_i;
  assign w_neg_in     = signed_i && (mcand_i[WIDTH-1] ^ mplier_i[WIDTH-1]);

  // One iteration: conditionally add the multiplicand into the upper half
  // (keeping the carry), then shift {carry, acc} right by one bit.
  assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
  assign w_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic: start from IDLE, return after the last iteration.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (st_i)   w_state_nxt = S_CALC;
      S_CALC:  if (w_last) w_state_nxt = S_IDLE;
      default:             w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: load operands on start, iterate in CALC, publish on completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_neg     <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_start) begin
        r_acc   <= {{WIDTH{1'b0}}, w_mplier_mag};
        r_mcand <= w_mcand_mag;
        r_neg   <= w_neg_in;
        r_cnt   <= '0;
      end else if (r_state == S_CALC) begin
        r_acc <= w_acc_nxt;
        r_cnt <= r_cnt + CW'(1);
        if (w_last) begin
          r_product <= r_neg ? negate(w_acc_nxt) : w_acc_nxt;
          r_done    <= 1'b1;
          r_cnt     <= '0;
        end
      end
    end
  end

  assign busy_o    = (r_state == S_CALC);
  assign done_o    = r_done;
  assign product_o = r_product;

endmodule

// File: doc/shift_add_multiplier_param.md
Name: shift_add_multiplier_param

Overview:
Parametrised sequential shift-and-add multiplier; next generation of the 4-bit controller/datapath multiplier.
Generalised to WIDTH-bit operands with a runtime signed/unsigned mode and a start/busy/done handshake that supports back-to-back operations.
Sits beside arithmetic datapaths that can tolerate WIDTH-cycle latency in exchange for minimal area.
Controller FSM and datapath live in one module.

Parameters:
WIDTH, 4, operand width in bits; legal range 2..32; product is 2*WIDTH bits.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  one clock; reset is asynchronous and active-high
st_i  input  1  start request; sampled only when not busy
signed_i  input  1  1 = two's-complement operands, 0 = unsigned; sampled with st_i
mcand_i  input  WIDTH  multiplicand; sampled with st_i
mplier_i  input  WIDTH  multiplier; sampled with st_i
busy_o  output  1  high while an operation is in progress
done_o  output  1  one-cycle pulse when product_o is updated
product_o  output  2*WIDTH  result register; holds last result until next completion

Behaviour:
- Reset (async, rst=1): state IDLE, busy_o=0, done_o=0, product_o=0, counter=0, internal acc/operand registers=0. Applies mid-operation: the in-flight operation is discarded and no done_o is generated.
- States: IDLE, CALC.
- IDLE:
  - st_i=1 at edge E0: capture the operands and signed_i, go to CALC, busy_o=1 from E0, counter=0.
  - When signed_i=1: store |mcand_i| and |mplier_i| as WIDTH-bit unsigned magnitudes (|-2^(WIDTH-1)| = 2^(WIDTH-1) fits), and latch neg = sign(mcand) XOR sign(mplier).
  - When signed_i=0: store operands unchanged, neg=0.
  - The accumulator upper half is cleared and the lower half is loaded with the multiplier magnitude.
- CALC, one iteration per edge:
  - If acc LSB=1, add the multiplicand magnitude to acc upper half with a WIDTH+1-bit carry.
  - Shift {carry, acc} right by 1; counter++.
- Final iteration (edge EW, W=WIDTH):
  - product_o <= neg ? two's-complement negation of the final acc (2*WIDTH bits) : final acc.
  - done_o=1 for the cycle after EW only; state goes to IDLE and busy_o=0 after EW.
- Latency: start at E0 -> product_o valid and done_o high after edge EW; fixed regardless of operand values, with no early termination.
- Back-to-back: st_i=1 during the done_o cycle is accepted (state is IDLE), so the next done arrives W edges later. Throughput is one result per W+1 cycles minimum.
- st_i while busy_o=1 is ignored. Operand and mode inputs are don't-care except in the start cycle.
- product_o changes only on completion or reset, never during CALC.
- Zero operands still take the full W cycles and give product 0. A negated zero yields 0; signed 0 * negative yields 0, never "-0".
- All arithmetic is exact: no overflow is possible in 2*WIDTH bits for either mode.

Test Plan:
- WIDTH=4, unsigned, mcand=15, mplier=15, st_i 1 cycle -> busy_o high 4 cycles; done_o one-cycle pulse after edge 4; product_o=0xE1 (225).
- WIDTH=4, signed: -8 * -8 -> 0x40; -8 * 7 -> 0xC8 (-56); 5 * -3 -> 0xF1 (-15); 0 * -5 -> 0x00.
- WIDTH=8, signed, -128 * 127 -> 0xC080 (-16256); unsigned, 255 * 255 -> 0xFE01; each completes exactly 8 edges after start.
- Back-to-back: hold st_i=1 continuously with operands 3*4, then 6*7 -> done pulses 5 cycles apart; product_o 12, then 42; second start accepted in first done cycle.
- Busy lockout: pulse st_i with 9*9, then pulse st_i with different operands at cycle 2 of CALC -> single done; product_o=81; no second operation.
- Reset mid-op: assert rst during cycle 2 of CALC -> immediately busy_o=0, done_o=0, product_o=0; no done after release; a new start then runs normally.
